// File: rtl/uno_pkg.sv
// Shared types and constants for the uno PE and its operation sequencer.
// MAC_BW can be overridden at build time with the MAC_BW macro.
`ifndef MAC_BW
`define MAC_BW 12
`endif

package uno_pkg;

  localparam int unsigned MAC_BW      = `MAC_BW;
  localparam int unsigned COEFF_TERMS = 4;

  typedef enum logic [1:0] {
    MAC = 2'b00,
    DIV = 2'b01,
    EXP = 2'b10,
    LOG = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MAC_RUN,
    POLY_RUN,
    DRAIN
  } seq_state_e;

  typedef logic [MAC_BW-1:0] coeff_t;

  // Polynomial coefficients, index 0 is issued on the first schedule cycle
  localparam coeff_t COEFF_DIV [COEFF_TERMS] = '{
    coeff_t'(12'h800), coeff_t'(12'hC00), coeff_t'(12'h600), coeff_t'(12'h300)
  };
  localparam coeff_t COEFF_EXP [COEFF_TERMS] = '{
    coeff_t'(12'h100), coeff_t'(12'h100), coeff_t'(12'h080), coeff_t'(12'h02B)
  };
  localparam coeff_t COEFF_LOG [COEFF_TERMS] = '{
    coeff_t'(12'h000), coeff_t'(12'h100), coeff_t'(12'hF80), coeff_t'(12'h055)
  };

endpackage

// File: rtl/uno_coeff_rom.sv
// Combinational coefficient lookup for the polynomial schedules.
// Returns zero for MAC and for steps beyond the stored tables.
module uno_coeff_rom
  import uno_pkg::*;
#(
  parameter int unsigned MAC_BW = uno_pkg::MAC_BW,
  parameter int unsigned TERMS  = 4,
  localparam int unsigned KW    = (TERMS > 1) ? $clog2(TERMS) : 1
) (
  input  logic [1:0]        op,
  input  logic [KW-1:0]     k,
  output logic [MAC_BW-1:0] coeff_c
);

  always_comb begin
    coeff_c = '0;
    if (32'(k) < COEFF_TERMS) begin
      case (op_e'(op))
        DIV:     coeff_c = MAC_BW'(COEFF_DIV[k]);
        EXP:     coeff_c = MAC_BW'(COEFF_EXP[k]);
        LOG:     coeff_c = MAC_BW'(COEFF_LOG[k]);
        default: coeff_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/uno_seq.sv
// Operation sequencer driving the uno MAC/nonlinear PE: MAC bursts and
// fixed-length polynomial schedules. UNO_SEQ_STATS_EN adds activity counters.
module uno_seq
  import uno_pkg::*;
#(
  parameter int unsigned MAC_BW = uno_pkg::MAC_BW,
  parameter int unsigned TERMS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [MAC_BW-1:0]     req_x,
  input  logic [MAC_BW-1:0]     req_y,
  input  logic [2*MAC_BW-1:0]   req_z,
  input  logic                  req_last,
  output logic [1:0]            op,
  output logic [MAC_BW-1:0]     X,
  output logic [MAC_BW-1:0]     Y,
  output logic [2*MAC_BW-1:0]   Z,
  output logic [MAC_BW-1:0]     coeff,
  output logic                  first_cycle,
  output logic                  last_cycle,
  output logic                  acc_en,
  output logic                  res_valid
`ifdef UNO_SEQ_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [31:0]           stat_busy
`endif
);

  localparam int unsigned KW     = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TERMS - 1);

  seq_state_e state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;
  logic [1:0]          op_q, op_d;
  logic [MAC_BW-1:0]   x_q, x_d, y_q, y_d, coeff_q, coeff_d;
  logic [2*MAC_BW-1:0] z_q, z_d;
  logic                first_q, first_d, lastc_q, lastc_d;
  logic                acc_q, acc_d, resv_q, resv_d;
  logic                hs_c;
  logic [1:0]          rom_op_c;
  logic [KW-1:0]       rom_k_c;
  logic [MAC_BW-1:0]   rom_coeff_c;

  assign hs_c = req_valid & ready_q;

  // Coefficient for the step being issued next cycle
  assign rom_op_c = (state_q == IDLE) ? req_op : op_q;
  assign rom_k_c  = (state_q == IDLE) ? '0 : k_q + KW'(1);

  uno_coeff_rom #(
    .MAC_BW (MAC_BW),
    .TERMS  (TERMS)
  ) u_rom (
    .op      (rom_op_c),
    .k       (rom_k_c),
    .coeff_c (rom_coeff_c)
  );

  // state_q always names the activity shown on the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      coeff_q <= '0;
      first_q <= 1'b0;
      lastc_q <= 1'b0;
      acc_q   <= 1'b0;
      resv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      coeff_q <= coeff_d;
      first_q <= first_d;
      lastc_q <= lastc_d;
      acc_q   <= acc_d;
      resv_q  <= resv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    ready_d = 1'b0;
    op_d    = op_q;
    x_d     = '0;
    y_d     = '0;
    z_d     = '0;
    coeff_d = '0;
    first_d = 1'b0;
    lastc_d = 1'b0;
    acc_d   = 1'b0;
    resv_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (hs_c) begin
          op_d = req_op;
          x_d  = req_x;
          y_d  = req_y;
          if (op_e'(req_op) == MAC) begin
            state_d = MAC_RUN;
            last_d  = req_last;
            z_d     = req_z;
            ready_d = ~req_last;
          end else begin
            state_d = POLY_RUN;
            k_d     = '0;
            coeff_d = rom_coeff_c;
            first_d = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      MAC_RUN: begin
        if (last_q) begin
          state_d = DRAIN;
          last_d  = 1'b0;
          resv_d  = 1'b1;
        end else begin
          // Without a beat the operands go to zero, holding the accumulator
          acc_d   = 1'b1;
          ready_d = 1'b1;
          if (hs_c) begin
            x_d     = req_x;
            y_d     = req_y;
            last_d  = req_last;
            ready_d = ~req_last;
          end
        end
      end
      POLY_RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          resv_d  = 1'b1;
        end else begin
          k_d     = k_q + KW'(1);
          x_d     = x_q;
          y_d     = y_q;
          coeff_d = rom_coeff_c;
          lastc_d = (k_d == K_LAST);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = ready_q;
  assign op          = op_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign Z           = z_q;
  assign coeff       = coeff_q;
  assign first_cycle = first_q;
  assign last_cycle  = lastc_q;
  assign acc_en      = acc_q;
  assign res_valid   = resv_q;

`ifdef UNO_SEQ_STATS_EN
  logic [15:0] ops_q;
  logic [31:0] busy_q;

  // Completed-operation count saturates; busy-cycle count wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q  <= '0;
      busy_q <= '0;
    end else begin
      if (resv_q && (ops_q != 16'hFFFF)) ops_q <= ops_q + 16'd1;
      if (state_q != IDLE) busy_q <= busy_q + 32'd1;
    end
  end

  assign stat_ops  = ops_q;
  assign stat_busy = busy_q;
`else
  // Statistics counters are not built in this configuration
`endif

endmodule
